encoder8_serializer: RTL

- Inverse of the 3-to-8 decoder with enable: takes an 8-bit request vector D and returns the index x of each set bit, highest index first, one code per accepted handshake.
- Captures D on a load strobe, then drains the captured bits through a valid/ready output port.
- Sits upstream of the decoder in the lab chain, so encoder x can drive decoder x for loop-back checking.

---
 rtl/enc_pkg.sv | 27 ++
 rtl/priority_enc8.sv | 36 +++
 rtl/encoder8_serializer.sv | 104 ++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// ============================================================================
// enc_pkg : shared types, default sizes and MSB-index helper for the encoder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package enc_pkg;

  localparam int W_DEF  = 8;
  localparam int XW_DEF = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [XW_DEF-1:0] msb_index(input logic [W_DEF-1:0] v);
    msb_index = '0;
    for (int i = 0; i < W_DEF; i++) begin
      if (v[i]) msb_index = XW_DEF'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/priority_enc8.sv
// ============================================================================
// priority_enc8 : combinational highest-set-bit encoder with any-bit flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module priority_enc8
  import enc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]         pending_i,
  output logic [$clog2(W)-1:0] x_o,
  output logic                 any_o
);

  localparam int XW = $clog2(W);

  assign any_o = |pending_i;

  generate
    if (W == W_DEF) begin : g_def
      assign x_o = msb_index(pending_i);
    end else begin : g_gen
      always_comb begin
        x_o = '0;
        for (int i = 0; i < W; i++) begin
          if (pending_i[i]) x_o = XW'(i);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/encoder8_serializer.sv
// ============================================================================
// encoder8_serializer : captures a request vector and emits set-bit indices,
// highest first, over valid/ready. Optional macro: ENC_MULTI_ERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module encoder8_serializer
  import enc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [W-1:0]         D,
  output logic [$clog2(W)-1:0] x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
`ifdef ENC_MULTI_ERR_EN
  output logic                 multi_err,
`endif
  output logic                 done
);

  localparam int XW = $clog2(W);
  localparam logic [W-1:0] ONE = W'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   pending_q, pending_d;
  logic           done_q, done_d;
  logic [XW-1:0]  w_x;
  logic           w_any;
  logic           w_xfer;
  logic           w_load_acc;

  priority_enc8 #(.W(W)) u_penc (
    .pending_i (pending_q),
    .x_o       (w_x),
    .any_o     (w_any)
  );

  assign busy       = (state_q == DRAIN);
  assign out_valid  = busy && en;
  assign x          = w_x;
  assign done       = done_q;
  assign w_xfer     = out_valid && out_ready;
  assign w_load_acc = en && load && (D != '0) && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_load_acc) begin
          pending_d = D;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_any) begin
          // Unreachable recovery: never sit in DRAIN with nothing pending.
          state_d = IDLE;
        end else if (w_xfer) begin
          pending_d = pending_q & ~(ONE << w_x);
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

`ifdef ENC_MULTI_ERR_EN
  logic multi_err_q;

  always_ff @(posedge clk) begin
    if (rst) multi_err_q <= 1'b0;
    else     multi_err_q <= w_load_acc && ((D & (D - ONE)) != '0);
  end

  assign multi_err = multi_err_q;
`endif

endmodule

`default_nettype wire
